led_counter_ctrl: RTL and testbench

LED_COUNTER_CTRL -- requirements
Module: led_counter_ctrl

---
 rtl/led_counter_ctrl.sv | 154 +++++++++++++++
 tb/tb_led_counter_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_counter_ctrl.sv
// -----------------------------------------------------------------------------
// led_counter_ctrl
//
// Two-button LED counter. Button A toggles run/pause and starts the counter
// from idle. Button B steps the counter while paused, or cycles the tick rate
// while running. Both buttons are synchronized and debounced, and only the
// press (1->0 of the debounced level) produces an event.
//
// Ports:
//   clk_12M  in   1  single clock, all state changes on its rising edge
//   rst_n    in   1  synchronous active-low reset
//   pmod     in   2  raw active-low buttons (asynchronous);
//                    [0] = A (run/pause), [1] = B (step/rate)
//   led      out  4  counter value
//   state    out  2  IDLE=00, RUN=01, PAUSE=10
//   rate     out  2  rate index r, tick frequency 2^r Hz
//   tick     out  1  one-cycle pulse on each counter advance in RUN
// -----------------------------------------------------------------------------
module led_counter_ctrl #(
    parameter int unsigned CLK_HZ          = 12000000,
    parameter int unsigned DEBOUNCE_CYCLES = 120000
) (
    input  logic       clk_12M,
    input  logic       rst_n,
    input  logic [1:0] pmod,
    output logic [3:0] led,
    output logic [1:0] state,
    output logic [1:0] rate,
    output logic       tick
);

    localparam int DIV_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10
    } state_e;

    // Input conditioning
    logic [1:0]            sync1_q, sync2_q;
    logic [1:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic [1:0]            db_lvl_q, db_lvl_d;
    logic [1:0]            press_q,  press_d;

    // Counter datapath and control
    state_e                state_q, state_d;
    logic [1:0]            rate_q,  rate_d;
    logic [DIV_W-1:0]      div_q,   div_d;
    logic [3:0]            led_q,   led_d;

    logic                  press_a, press_b;
    logic [DIV_W-1:0]      period_m1;
    logic                  tick_c;

    // NOTE: every signal driven from always_comb gets a default on entry so
    // that no path leaves it unassigned, which would infer a latch.
    always_comb begin
        db_cnt_d = db_cnt_q;
        db_lvl_d = db_lvl_q;
        press_d  = 2'b00;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == db_lvl_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
                // Level has differed long enough: accept it. A press is an
                // accepted 1->0, i.e. the old debounced level was 1.
                db_lvl_d[i] = sync2_q[i];
                db_cnt_d[i] = '0;
                press_d[i]  = db_lvl_q[i];
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
        end
    end

    // A wins over a simultaneous B, so B is only honoured on its own.
    assign press_a   = press_q[0];
    assign press_b   = press_q[1] & ~press_q[0];

    assign period_m1 = DIV_W'((CLK_HZ >> rate_q) - 1);

    // Decoded from registered state and registered press events only; a rate
    // change in the same cycle clears the divider and suppresses the tick.
    assign tick_c    = (state_q == S_RUN) && !press_b && (div_q == period_m1);

    always_comb begin
        state_d = state_q;
        rate_d  = rate_q;
        div_d   = div_q;
        led_d   = led_q;
        unique case (state_q)
            S_IDLE: begin
                div_d = '0;
                if (press_a) state_d = S_RUN;
            end
            S_RUN: begin
                if (press_a) state_d = S_PAUSE;
                if (press_b) begin
                    rate_d = rate_q + 2'd1;
                    div_d  = '0;
                end else if (tick_c) begin
                    div_d  = '0;
                    led_d  = led_q + 4'd1;
                end else begin
                    div_d  = div_q + 1'b1;
                end
            end
            S_PAUSE: begin
                // Divider holds so counting resumes from where it stopped.
                if (press_a)      state_d = S_RUN;
                else if (press_b) led_d   = led_q + 4'd1;
            end
            default: begin
                state_d = S_IDLE;
                div_d   = '0;
            end
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers see the pre-edge values of each other.
    always_ff @(posedge clk_12M) begin
        if (!rst_n) begin
            sync1_q  <= 2'b11;
            sync2_q  <= 2'b11;
            db_cnt_q <= '0;
            db_lvl_q <= 2'b11;
            press_q  <= 2'b00;
            state_q  <= S_IDLE;
            rate_q   <= 2'd0;
            div_q    <= '0;
            led_q    <= 4'd0;
        end else begin
            sync1_q  <= pmod;
            sync2_q  <= sync1_q;
            db_cnt_q <= db_cnt_d;
            db_lvl_q <= db_lvl_d;
            press_q  <= press_d;
            state_q  <= state_d;
            rate_q   <= rate_d;
            div_q    <= div_d;
            led_q    <= led_d;
        end
    end

    assign led   = led_q;
    assign state = state_q;
    assign rate  = rate_q;
    assign tick  = tick_c;

endmodule

// File: tb/tb_led_counter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_led_counter_ctrl
//
// Scoreboard bench for led_counter_ctrl (CLK_HZ=64, DEBOUNCE_CYCLES=4).
// Stimulus pushes the expected cycle and output snapshot of every output
// change it provokes; the monitor pops one entry each time any output changes.
// -----------------------------------------------------------------------------
module tb_led_counter_ctrl;

    localparam int CLK_HZ = 64;
    localparam int DEB    = 4;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;

    logic       clk_12M = 1'b0;
    logic       rst_n;
    logic [1:0] pmod;
    logic [3:0] led;
    logic [1:0] state;
    logic [1:0] rate;
    logic       tick;

    led_counter_ctrl #(
        .CLK_HZ          (CLK_HZ),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk_12M (clk_12M),
        .rst_n   (rst_n),
        .pmod    (pmod),
        .led     (led),
        .state   (state),
        .rate    (rate),
        .tick    (tick)
    );

    always #5 clk_12M = ~clk_12M;

    // Cycle n is the interval after the n-th rising edge.
    int cyc = 0;
    always @(posedge clk_12M) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic [8:0] snap;   // {state, rate, led, tick}
    } exp_t;

    exp_t       exp_q[$];
    int         n_cmp  = 0;
    int         n_bad  = 0;
    bit         mon_en = 1'b0;
    logic [8:0] prev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic void push(input int at, input logic [1:0] st, input logic [1:0] rt,
                                 input logic [3:0] ld, input logic tk);
        exp_t e;
        e.at   = at;
        e.snap = {st, rt, ld, tk};
        exp_q.push_back(e);
    endfunction

    // Monitor: every change of any output must match the next expected entry.
    always @(negedge clk_12M) begin
        logic [8:0] snap;
        exp_t       e;
        if (mon_en) begin
            snap = {state, rate, led, tick};
            if (snap !== prev) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_event: got 0x%0h, want no change from 0x%0h (cycle %0d)",
                             snap, prev, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("event_cycle", 32'(cyc), 32'(e.at));
                    check("event_outputs", {23'd0, snap}, {23'd0, e.snap});
                end
            end
            prev = snap;
        end
    end

    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clk_12M);
            #1;
        end
    endtask

    // Hold a button low for 6 cycles from now; its press event lands in the
    // cycle this task returns in (start + 2 + DEB).
    task automatic press(input int btn);
        int s;
        s = cyc;
        pmod[btn] = 1'b0;
        goto(s + 6);
        pmod[btn] = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, p, per, pa, s, r0, pr, u0, pu, z;
        int led_e;

        // Reset held for three edges with buttons released.
        rst_n = 1'b0;
        pmod  = 2'b11;
        goto(3);
        check("reset_led",   {28'd0, led},   32'd0);
        check("reset_state", {30'd0, state}, 32'd0);
        check("reset_rate",  {30'd0, rate},  32'd0);
        check("reset_tick",  {31'd0, tick},  32'd0);
        prev   = {state, rate, led, tick};
        mon_en = 1'b1;
        rst_n  = 1'b1;

        // Bounce: A low for 3 cycles is shorter than the debounce window.
        goto(5);
        pmod = 2'b10;
        goto(8);
        pmod = 2'b11;
        goto(20);
        check("bounce_state", {30'd0, state}, 32'd0);

        // Run: A held 10 cycles, RUN at +7, then 16 ticks every 64 cycles.
        c0 = cyc;
        push(c0 + 7, ST_RUN, 2'd0, 4'd0, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            push(c0 + 6 + 64 * k,     ST_RUN, 2'd0, 4'((k - 1) % 16), 1'b1);
            push(c0 + 6 + 64 * k + 1, ST_RUN, 2'd0, 4'(k % 16),       1'b0);
        end
        pmod = 2'b10;
        goto(c0 + 10);
        pmod = 2'b11;
        goto(c0 + 1032);

        // Rate: three B presses in RUN, two ticks observed at each rate.
        led_e = 0;
        for (int r = 1; r <= 3; r++) begin
            p   = cyc + 6;
            per = CLK_HZ >> r;
            push(p + 1, ST_RUN, 2'(r), 4'(led_e), 1'b0);
            for (int k = 1; k <= 2; k++) begin
                push(p + per * k, ST_RUN, 2'(r), 4'(led_e), 1'b1);
                led_e++;
                push(p + per * k + 1, ST_RUN, 2'(r), 4'(led_e), 1'b0);
            end
            press(1);
            goto(p + 2 * per + 1);
        end

        // Pause: divider is at 6 in the press cycle and holds at 7.
        pa = cyc + 6;
        push(pa + 1, ST_PAUSE, 2'd3, 4'(led_e), 1'b0);
        press(0);
        goto(pa + 1 + 200);

        // Step: two B presses in PAUSE, each +1 with no tick.
        for (int i = 0; i < 2; i++) begin
            s = cyc;
            led_e++;
            push(s + 7, ST_PAUSE, 2'd3, 4'(led_e), 1'b0);
            press(1);
            goto(s + 20);
        end

        // Resume: held divider value 7 ticks in the very first RUN cycle.
        r0 = cyc;
        pr = r0 + 6;
        push(pr + 1,  ST_RUN,   2'd3, 4'(led_e),     1'b1);
        push(pr + 2,  ST_RUN,   2'd3, 4'(led_e + 1), 1'b0);
        push(pr + 9,  ST_RUN,   2'd3, 4'(led_e + 1), 1'b1);
        push(pr + 10, ST_RUN,   2'd3, 4'(led_e + 2), 1'b0);
        push(pr + 17, ST_RUN,   2'd3, 4'(led_e + 2), 1'b1);
        push(pr + 18, ST_RUN,   2'd3, 4'(led_e + 3), 1'b0);
        push(pr + 19, ST_PAUSE, 2'd3, 4'(led_e + 3), 1'b0);
        led_e += 3;
        press(0);
        goto(pr + 12);
        press(0);
        goto(pr + 40);

        // Simultaneous A+B in PAUSE: back to RUN, led unchanged, divider held at 1.
        u0 = cyc;
        pu = u0 + 6;
        push(pu + 1, ST_RUN, 2'd3, 4'(led_e),     1'b0);
        push(pu + 7, ST_RUN, 2'd3, 4'(led_e),     1'b1);
        push(pu + 8, ST_RUN, 2'd3, 4'(led_e + 1), 1'b0);
        pmod = 2'b00;
        goto(u0 + 6);
        pmod = 2'b11;

        // Reset mid-RUN, then A held through reset release.
        goto(pu + 10);
        z = cyc;
        push(z + 1, ST_IDLE, 2'd0, 4'd0, 1'b0);
        push(z + 9, ST_RUN,  2'd0, 4'd0, 1'b0);
        rst_n = 1'b0;
        goto(z + 1);
        pmod = 2'b10;
        goto(z + 2);
        rst_n = 1'b1;
        goto(z + 12);
        pmod = 2'b11;
        goto(z + 40);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
